pc_sequencer: RTL and testbench

- Owns the 12-bit program counter and sequences instruction fetch for the single-issue core.
- Chooses the next PC from increment, branch, jump/jal and jr, in that rising priority.
- Runs a fetch handshake with instruction memory and discards fetches made stale by a redirect.
- Supplies the 32-bit zero-extended PC+1 link value to decode/writeback.

---
 rtl/core_pkg.sv | 11 +
 rtl/pc_inc_unit.sv | 11 +
 rtl/pc_sequencer.sv | 82 ++++++++
 tb/tb_pc_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared widths, reset PC, sequencer states and redirect select for instruction fetch
package core_pkg;
  localparam int PC_W = 12;
  localparam int DATA_W = 32;
  localparam logic [PC_W-1:0] RESET_PC = '0;
  typedef enum logic [1:0] {IDLE, REQ, FULL, HALT} seq_state_t;
  typedef enum logic [1:0] {SEL_INC, SEL_BR, SEL_JMP, SEL_JR} redir_sel_t;
  function automatic redir_sel_t redir_sel(input logic jr, input logic jmp, input logic br);
    return jr ? SEL_JR : jmp ? SEL_JMP : br ? SEL_BR : SEL_INC;
  endfunction
endpackage

// File: rtl/pc_inc_unit.sv
// pc_inc_unit: zero-extended DATA_W pc+1 (link value) and its PC_W wrapping truncation
module pc_inc_unit
  import core_pkg::*;
(
  input  logic [PC_W-1:0]   pc_i,
  output logic [DATA_W-1:0] link_o,
  output logic [PC_W-1:0]   pc_inc_o
);
  assign link_o = {{(DATA_W-PC_W){1'b0}}, pc_i} + DATA_W'(1);
  assign pc_inc_o = link_o[PC_W-1:0];
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter, redirect priority and fetch handshake with stale-ack kill
module pc_sequencer
  import core_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [PC_W-1:0]   if_pc,
  output logic [DATA_W-1:0] link_val,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_target,
  input  logic              jmp,
  input  logic [PC_W-1:0]   jmp_target,
  input  logic              jr,
  input  logic [PC_W-1:0]   jr_target,
  input  logic              halt,
  output logic              halted
);
  seq_state_t state_q, state_d;
  redir_sel_t sel;
  logic [PC_W-1:0] pc_q, pc_d, addr_q, addr_d, if_pc_q, if_pc_d, pc_inc, target;
  logic [DATA_W-1:0] instr_q, instr_d, link_q, link_d, link_nxt;
  logic kill_q, kill_d, halt_q, halt_d;
  logic halt_any, redir, xfer, ack_ok;
  pc_inc_unit u_inc (.pc_i(pc_q), .link_o(link_nxt), .pc_inc_o(pc_inc));
  always_comb begin
    halt_any = halt | halt_q;
    sel = redir_sel(jr, jmp, br_taken);
    redir = sel != SEL_INC && !halt_any;
    target = sel == SEL_JR ? jr_target : sel == SEL_JMP ? jmp_target : br_target;
    xfer = state_q == FULL && if_ready;
    ack_ok = state_q == REQ && imem_ack && !kill_q && !redir;
    pc_d = redir ? target : xfer ? pc_inc : pc_q;
    addr_d = state_q == REQ && !imem_ack ? addr_q : pc_d;
    kill_d = state_q == REQ && !imem_ack && (kill_q || redir);
    halt_d = halt_any;
    instr_d = ack_ok ? imem_rdata : instr_q;
    if_pc_d = ack_ok ? pc_q : if_pc_q;
    link_d = ack_ok ? link_nxt : link_q;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = halt_any ? HALT : stall ? IDLE : REQ;
      REQ:     state_d = !imem_ack ? REQ : halt_any ? HALT : ack_ok ? FULL : REQ;
      FULL:    state_d = halt_any ? HALT : !(redir || xfer) ? FULL : stall ? IDLE : REQ;
      default: state_d = HALT;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      if_pc_q <= '0;
      instr_q <= '0;
      link_q  <= '0;
      kill_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      if_pc_q <= if_pc_d;
      instr_q <= instr_d;
      link_q  <= link_d;
      kill_q  <= kill_d;
      halt_q  <= halt_d;
    end
  assign imem_req = state_q == REQ;
  assign imem_addr = addr_q;
  assign if_valid = state_q == FULL;
  assign halted = state_q == HALT;
  assign if_instr = instr_q;
  assign if_pc = if_pc_q;
  assign link_val = link_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized fetch stimulus with a scoreboard of expected fetch PCs
module tb_pc_sequencer;
  logic clock = 0, reset;
  logic imem_req, imem_ack, if_valid, if_ready, stall, br_taken, jmp, jr, halt, halted;
  logic [11:0] imem_addr, if_pc, br_target, jmp_target, jr_target;
  logic [31:0] imem_rdata, if_instr, link_val;
  int checks = 0, failures = 0, xfers = 0, lat_fix, rd_seq, rd_seen;
  logic stray;
  logic [11:0] rd_tgt, sb_e;
  logic [11:0] exp_q[$];

  pc_sequencer dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .link_val(link_val), .stall(stall),
    .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target),
    .jr(jr), .jr_target(jr_target), .halt(halt), .halted(halted)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] memf(input logic [11:0] a);
    return {a, 8'h5A, ~a} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [11:0] rt();
    return $urandom_range(0, 3) == 0 ? 12'(12'hFFF - 12'($urandom_range(0, 2))) : 12'($urandom);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    smp();
    while (!imem_req && n < 40) begin smp(); n++; end
    chk({nm, "_req"}, 32'(imem_req), 1);
  endtask

  task automatic wait_ack(input string nm);
    int n = 0;
    smp();
    while (!imem_ack && n < 40) begin smp(); n++; end
    chk({nm, "_ack"}, 32'(imem_ack), 1);
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    smp();
    while (!if_valid && n < 40) begin smp(); n++; end
    chk({nm, "_valid"}, 32'(if_valid), 1);
  endtask

  task automatic redirect(input logic a_jr, input logic a_jmp, input logic a_br,
                          input logic [11:0] t_jr, input logic [11:0] t_jmp,
                          input logic [11:0] t_br, input bit mdl);
    jr = a_jr; jmp = a_jmp; br_taken = a_br;
    jr_target = t_jr; jmp_target = t_jmp; br_target = t_br;
    if_ready = 0;
    if (mdl) begin
      rd_tgt = a_jr ? t_jr : a_jmp ? t_jmp : t_br;
      rd_seq++;
    end
    step();
    jr = 0; jmp = 0; br_taken = 0; if_ready = 1;
  endtask

  initial begin : mem
    int cnt;
    cnt = -1;
    imem_ack = 0;
    imem_rdata = 0;
    forever begin
      step();
      imem_ack = 0;
      if (stray) imem_ack = 1;
      else if (!reset) cnt = -1;
      else if (imem_req) begin
        if (cnt < 0) cnt = lat_fix != 0 ? lat_fix : int'($urandom_range(1, 3));
        if (cnt == 0) begin
          imem_ack = 1;
          imem_rdata = memf(imem_addr);
          cnt = -1;
        end else cnt--;
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      exp_q.delete();
      exp_q.push_back(12'h000);
      rd_seen = rd_seq;
    end else begin
      if (rd_seq != rd_seen) begin
        rd_seen = rd_seq;
        exp_q.delete();
        exp_q.push_back(rd_tgt);
      end
      if (if_valid && if_ready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty got_pc=%0h exp=none", if_pc);
        end else begin
          sb_e = exp_q.pop_front();
          chk("sb_pc", 32'(if_pc), 32'(sb_e));
          chk("sb_instr", if_instr, memf(sb_e));
          chk("sb_link", link_val, 32'(sb_e) + 32'd1);
          exp_q.push_back(sb_e + 12'd1);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int n, v, x0;
    logic [11:0] rp;
    logic [31:0] ri;
    logic [2:0] a;
    reset = 0; if_ready = 1; stall = 0; halt = 0; stray = 0;
    br_taken = 0; jmp = 0; jr = 0; br_target = 0; jmp_target = 0; jr_target = 0;
    lat_fix = 1; rd_seq = 0; rd_tgt = 0;
    repeat (3) smp();
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_valid", 32'(if_valid), 0);
    chk("rst_instr", if_instr, 0);
    chk("rst_pc", 32'(if_pc), 0);
    chk("rst_link", link_val, 0);
    chk("rst_halted", 32'(halted), 0);
    step();
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      wait_req("seq");
      chk("seq_addr", 32'(imem_addr), i);
      wait_ack("seq");
      smp();
      chk("seq_valid", 32'(if_valid), 1);
      chk("seq_pc", 32'(if_pc), i);
      chk("seq_link", link_val, i + 1);
    end
    lat_fix = 3;
    n = 0;
    smp();
    while (!(imem_req && imem_addr == 12'h005) && n < 40) begin smp(); n++; end
    chk("kill_setup", 32'(imem_addr), 32'h5);
    step();
    redirect(0, 1, 1, 12'h000, 12'h100, 12'h040, 1);
    n = 0; v = 0;
    smp();
    while (imem_addr == 12'h005 && n < 20) begin v += int'(if_valid); smp(); n++; end
    chk("kill_no_valid", v, 0);
    chk("kill_addr", 32'(imem_addr), 32'h100);
    chk("kill_req", 32'(imem_req), 1);
    lat_fix = 1;
    step();
    redirect(0, 1, 0, 12'h000, 12'hFFE, 12'h000, 1);
    n = 0;
    smp();
    while (!(if_valid && if_pc == 12'hFFF) && n < 40) begin smp(); n++; end
    chk("wrap_pc", 32'(if_pc), 32'hFFF);
    chk("wrap_link", link_val, 32'h0000_1000);
    wait_req("wrap");
    chk("wrap_addr", 32'(imem_addr), 0);
    step();
    if_ready = 0; stall = 1;
    wait_valid("stall");
    rp = if_pc; ri = if_instr;
    repeat (5) begin
      smp();
      chk("stall_valid", 32'(if_valid), 1);
      chk("stall_instr", if_instr, ri);
      chk("stall_pc", 32'(if_pc), 32'(rp));
      chk("stall_req", 32'(imem_req), 0);
    end
    step();
    stall = 0; if_ready = 1;
    wait_req("unstall");
    chk("unstall_addr", 32'(imem_addr), 32'(rp + 12'd1));
    lat_fix = 3;
    wait_valid("halt");
    wait_req("halt");
    step();
    halt = 1;
    step();
    halt = 0;
    wait_ack("halt");
    smp();
    chk("halt_halted", 32'(halted), 1);
    chk("halt_req0", 32'(imem_req), 0);
    chk("halt_valid0", 32'(if_valid), 0);
    step();
    redirect(1, 0, 0, 12'h234, 12'h000, 12'h000, 0);
    repeat (4) begin
      smp();
      chk("halt_jr_req", 32'(imem_req), 0);
      chk("halt_stay", 32'(halted), 1);
    end
    step();
    reset = 0;
    step();
    reset = 1;
    wait_req("arst");
    #2 reset = 0;
    #1;
    chk("arst_req", 32'(imem_req), 0);
    chk("arst_valid", 32'(if_valid), 0);
    chk("arst_halted", 32'(halted), 0);
    stray = 1;
    @(posedge clock);
    #2 stray = 0;
    repeat (3) begin
      smp();
      chk("arst_late_ack", 32'(if_valid), 0);
    end
    step();
    reset = 1;
    lat_fix = 1;
    wait_req("arst_rel");
    chk("arst_addr", 32'(imem_addr), 0);
    wait_ack("arst_rel");
    smp();
    chk("arst_pc", 32'(if_pc), 0);
    chk("arst_instr", if_instr, memf(12'h000));
    lat_fix = 0;
    x0 = xfers;
    step();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        a = 3'($urandom_range(1, 7));
        redirect(a[2], a[1], a[0], rt(), rt(), rt(), 1);
      end else begin
        if_ready = $urandom_range(0, 9) < 7;
        stall = $urandom_range(0, 9) == 0;
        step();
      end
    end
    stall = 0;
    if_ready = 1;
    repeat (20) step();
    chk("progress", 32'(xfers - x0 > 40), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
